ls_port_arbiter: RTL
====================

// Module: ls_port_arbiter
// PURPOSE
//  Single-port arbiter/sequencer for the 32KB SPU local store. Shares one quadword
//  access per cycle between three requesters: MFC DMA, the load/store pipe and
//  instruction fetch. Sits between those requesters and the LS SRAM macro.
//  Issues SRAM commands and routes read data back to the owner after a fixed latency.
// PARAMETERS
//  MEM_LAT       6   cycles from registered mem_en (read) to valid mem_rdata; range 1..8
//  STARVE_LIMIT  8   consecutive denied cycles before ifetch is promoted to top priority
// PORTS
//  clk        in   1    clock
//  reset      in   1    synchronous active-high reset
//  dma_valid  in   1    DMA request
//  dma_we     in   1    1=store quadword, 0=load
//  dma_addr   in   15   byte address; low 4 bits ignored
//  dma_wdata  in   128  store data
//  dma_ready  out  1    DMA request accepted this cycle
//  dma_rvalid out  1    rdata holds DMA load result
//  lsu_valid/lsu_we/lsu_addr[15]/lsu_wdata[128]  in   same meaning, load/store pipe
//  lsu_ready  out  1    LSU request accepted;  lsu_rvalid out 1  rdata is LSU result
//  if_valid   in   1    ifetch read request (read-only requester)
//  if_addr    in   15   fetch byte address, low 4 bits ignored
//  if_flush   in   1    branch taken: discard in-flight and same-cycle fetches
//  if_ready   out  1    fetch accepted;  if_rvalid out 1  rdata is fetch result
//  mem_en     out  1    SRAM access strobe (registered)
//  mem_we     out  1    SRAM write enable (registered)
//  mem_addr   out  15   quadword-aligned address, mem_addr[11:14]==0 always
//  mem_wdata  out  128  SRAM write data (registered)
//  mem_rdata  in   128  SRAM read data, valid MEM_LAT cycles after read mem_en
//  rdata      out  128  shared return data = mem_rdata (combinational pass-through)
// BEHAVIOUR
//  - Reset: all outputs 0; in-flight tags cleared (pending reads never raise rvalid);
//    starvation counter 0. Reset mid-operation discards everything.
//  - Accept: *_ready is combinational from *_valid, if_flush and starvation state; at most
//    one ready per cycle; ready never asserted without matching valid. Request completes
//    in the cycle valid&ready; requester holds fields stable until then.
//  - Priority: DMA > LSU > IF normally. When starve_cnt==STARVE_LIMIT: IF > DMA > LSU.
//  - starve_cnt: +1 (saturating) each cycle if_valid&!if_ready&!if_flush; cleared on
//    IF accept, on !if_valid, or on if_flush.
//  - if_flush: if_ready=0 that cycle; every in-flight IF tag invalidated, so no if_rvalid
//    for fetches accepted before or in that cycle. DMA/LSU unaffected; slot goes to them.
//  - Issue: cycle N accept -> cycle N+1 mem_en=1, mem_we=req_we (IF always 0),
//    mem_addr={addr[0:10],4'b0}, mem_wdata=wdata. No accept -> mem_en=0, mem_we=0.
//  - Return: read issued at N+1 -> owner rvalid=1 at N+1+MEM_LAT for exactly one
//    cycle, rdata=mem_rdata. At most one rvalid per cycle. Stores produce no rvalid.
//    Tag pipeline: (MEM_LAT+1)-deep shift register of {valid,owner[1:0]}, one read
//    in flight per slot, fully pipelined (back-to-back reads every cycle).
//  - Ordering: SRAM access order == accept order; store then load to same quadword
//    on consecutive cycles returns the new data (SRAM is write-before-read ordered).
//  - No backpressure on returns: requesters must sink rvalid unconditionally.
// TESTING
//  1 Reset: drive all valids=1 during reset -> all ready/rvalid/mem_en=0; first cycle
//    after reset DMA granted, mem_en=1 next cycle.
//  2 Priority: dma, lsu, if_valid=1 same cycle -> dma_ready=1 only; drop dma_valid ->
//    lsu_ready next; IF served only when both idle.
//  3 Latency: LSU store 0x0123 data 128'hA5.. then load 0x0120 -> mem_addr=15'h0120
//    both; lsu_rvalid exactly 1+MEM_LAT(=7) cycles after load accept, rdata=128'hA5..
//  4 Starvation: DMA valid continuous, if_valid=1 -> if_ready=1 on the 9th cycle
//    (STARVE_LIMIT=8), DMA stalled that cycle, counter back to 0 after.
//  5 Flush: 3 back-to-back fetches, if_flush 2 cycles later -> zero if_rvalid pulses;
//    interleaved LSU load still returns its rvalid on schedule.
//  6 Reset mid-flight: 4 reads outstanding, assert reset 1 cycle -> no rvalid afterwards.

Source files
------------

// File: rtl/ls_port_arbiter_if.sv
// Request, return and SRAM-side signals of the SPU local-store port arbiter.
// The arbiter takes the slave view; requesters and the SRAM macro take the master view.
interface ls_port_arbiter_if;
  logic         dma_valid;
  logic         dma_we;
  logic [14:0]  dma_addr;
  logic [127:0] dma_wdata;
  logic         dma_ready;
  logic         dma_rvalid;

  logic         lsu_valid;
  logic         lsu_we;
  logic [14:0]  lsu_addr;
  logic [127:0] lsu_wdata;
  logic         lsu_ready;
  logic         lsu_rvalid;

  logic         if_valid;
  logic [14:0]  if_addr;
  logic         if_flush;
  logic         if_ready;
  logic         if_rvalid;

  logic         mem_en;
  logic         mem_we;
  logic [14:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic [127:0] rdata;

  modport master (
    output dma_valid, dma_we, dma_addr, dma_wdata,
    input  dma_ready, dma_rvalid,
    output lsu_valid, lsu_we, lsu_addr, lsu_wdata,
    input  lsu_ready, lsu_rvalid,
    output if_valid, if_addr, if_flush,
    input  if_ready, if_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  rdata
  );

  modport slave (
    input  dma_valid, dma_we, dma_addr, dma_wdata,
    output dma_ready, dma_rvalid,
    input  lsu_valid, lsu_we, lsu_addr, lsu_wdata,
    output lsu_ready, lsu_rvalid,
    input  if_valid, if_addr, if_flush,
    output if_ready, if_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output rdata
  );
endinterface

// File: rtl/ls_port_arbiter.sv
// Single-port local-store arbiter: one quadword access per cycle shared by DMA, LSU
// and ifetch, with a read-owner tag pipeline that routes SRAM return data back.
module ls_port_arbiter #(
  parameter int MEM_LAT      = 6,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  ls_port_arbiter_if.slave bus
);
  localparam int DATA_W = 128;
  localparam int ADDR_W = 15;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] QW_MASK = 15'h7FF0;

  localparam logic [1:0] OWN_DMA = 2'd0;
  localparam logic [1:0] OWN_LSU = 2'd1;
  localparam logic [1:0] OWN_IF  = 2'd2;

  logic [CNT_W-1:0]  starve_cnt;
  logic              promote;
  logic              if_ok;
  logic              dma_rdy;
  logic              lsu_rdy;
  logic              if_rdy;
  logic              accept;
  logic              acc_we;
  logic [1:0]        acc_own;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  logic              mem_en_p0;
  logic              mem_we_p0;
  logic [ADDR_W-1:0] mem_addr_p0;
  logic [DATA_W-1:0] mem_wdata_p0;

  logic [MEM_LAT:0]  tag_vld;
  logic [1:0]        tag_own [0:MEM_LAT];
  logic              ret_vld;

  assign promote = (starve_cnt == CNT_MAX);
  assign if_ok   = bus.if_valid & ~bus.if_flush;

  // A starved fetch jumps ahead of DMA and LSU for one grant.
  always_comb begin
    dma_rdy   = 1'b0;
    lsu_rdy   = 1'b0;
    if_rdy    = 1'b0;
    acc_own   = OWN_DMA;
    acc_we    = bus.dma_we;
    acc_addr  = bus.dma_addr;
    acc_wdata = bus.dma_wdata;
    if (!reset) begin
      if (promote && if_ok)  if_rdy  = 1'b1;
      else if (bus.dma_valid) dma_rdy = 1'b1;
      else if (bus.lsu_valid) lsu_rdy = 1'b1;
      else if (if_ok)         if_rdy  = 1'b1;
    end
    if (lsu_rdy) begin
      acc_own   = OWN_LSU;
      acc_we    = bus.lsu_we;
      acc_addr  = bus.lsu_addr;
      acc_wdata = bus.lsu_wdata;
    end else if (if_rdy) begin
      acc_own   = OWN_IF;
      acc_we    = 1'b0;
      acc_addr  = bus.if_addr;
      acc_wdata = '0;
    end
  end

  assign accept = dma_rdy | lsu_rdy | if_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!bus.if_valid || bus.if_flush || if_rdy) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // ---- stage p0: registered SRAM command ----
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en_p0    <= 1'b0;
      mem_we_p0    <= 1'b0;
      mem_addr_p0  <= '0;
      mem_wdata_p0 <= '0;
    end else begin
      mem_en_p0    <= accept;
      mem_we_p0    <= accept & acc_we;
      mem_addr_p0  <= acc_addr & QW_MASK;
      mem_wdata_p0 <= acc_wdata;
    end
  end

  // ---- read-owner tags: slot k is the read issued k cycles ago; a flush kills IF slots ----
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0] <= accept & ~acc_we;
      for (int k = 1; k <= MEM_LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1] & ~(bus.if_flush & (tag_own[k-1] == OWN_IF));
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_own[0] <= acc_own;
    for (int k = 1; k <= MEM_LAT; k++) begin
      tag_own[k] <= tag_own[k-1];
    end
  end

  assign ret_vld = tag_vld[MEM_LAT] & ~reset;

  assign bus.dma_ready  = dma_rdy;
  assign bus.lsu_ready  = lsu_rdy;
  assign bus.if_ready   = if_rdy;
  assign bus.dma_rvalid = ret_vld & (tag_own[MEM_LAT] == OWN_DMA);
  assign bus.lsu_rvalid = ret_vld & (tag_own[MEM_LAT] == OWN_LSU);
  assign bus.if_rvalid  = ret_vld & (tag_own[MEM_LAT] == OWN_IF) & ~bus.if_flush;
  assign bus.mem_en     = mem_en_p0;
  assign bus.mem_we     = mem_we_p0;
  assign bus.mem_addr   = mem_addr_p0;
  assign bus.mem_wdata  = mem_wdata_p0;
  assign bus.rdata      = bus.mem_rdata;
endmodule
